serial_alu_seq: RTL and testbench

Parametrised digit-serial ALU sequencer, the successor to the fixed nibble-loop ALU used by the control FSM. It processes operands DIGIT bits per clock, LSB digit first, over XLEN-bit words. It adds sign-extended short operands, subtraction, logic ops and signed/unsigned compares, and exits early on ADD once the remaining result digits are known to equal word1. It sits between the control FSM (start/op/len issue) and the register file / PC / memory-address paths (result consumers).

---
 rtl/serial_alu_seq.sv | 167 ++++++++++++++++
 tb/tb_serial_alu_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_seq.sv
// Digit-serial ALU sequencer: XLEN-bit operands processed DIGIT bits per clock, LSB digit
// first, with an ADD early exit once the remaining result digits are known to equal word1.
module serial_alu_seq #(
   parameter int XLEN  = 32,
   parameter int DIGIT = 4,
   parameter int LW    = $clog2(XLEN / DIGIT)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      op,
   input  logic [LW-1:0]   len,
   input  logic            w2_signed,
   input  logic [XLEN-1:0] word1,
   input  logic [XLEN-1:0] word2,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            carry,
   output logic            flag,
   output logic            zero
);

   localparam int N  = XLEN / DIGIT;
   localparam int XW = $clog2(XLEN);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
   typedef enum logic [2:0] {
      OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
      OP_XOR = 3'b100, OP_EQ  = 3'b101, OP_LTU = 3'b110, OP_LT  = 3'b111
   } op_e;

   state_e            state_q, state_d;
   op_e               op_q;
   logic [LW-1:0]     len_q, idx_q;
   logic              cin_q, eq_acc_q, fill_q;
   logic [XLEN-1:0]   w2x_q, result_q;
   logic              carry_q, flag_q, zero_q;

   logic              accept, op_inv, fill;
   logic [LW-1:0]     len_c;
   logic [XW-1:0]     sign_pos, digit_base;
   logic [XLEN-1:0]   w2_ext, result_nxt;
   logic [DIGIT-1:0]  w1_dig, w2_dig, dig_res;
   logic [DIGIT:0]    sum_ext;
   logic              is_arith, last_dig, early_exit, finish, flag_d;
   logic              w1_sign, w2_sign;

   // A start coinciding with flush is dropped, and nothing is accepted while running.
   assign accept = start && !flush && (state_q != S_RUN);
   assign op_inv = (op_e'(op) == OP_SUB) || (op_e'(op) == OP_LTU) || (op_e'(op) == OP_LT);

   // Operand-side extension of word2, evaluated only for the accept edge.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      w2_ext   = '0;
      len_c    = (int'(len) > N - 1) ? LW'(N - 1) : len;
      sign_pos = XW'((int'(len_c) + 1) * DIGIT - 1);
      fill     = w2_signed & word2[sign_pos];
      for (int d = 0; d < N; d++) begin
         w2_ext[d*DIGIT +: DIGIT] = (d > int'(len_c)) ? {DIGIT{fill}} : word2[d*DIGIT +: DIGIT];
      end
      if (op_inv) w2_ext = ~w2_ext;
   end

   // Digit datapath: result_q doubles as word1 storage for digits not yet processed.
   always_comb begin
      digit_base = XW'(int'(idx_q) * DIGIT);
      w1_dig     = result_q[digit_base +: DIGIT];
      w2_dig     = w2x_q[digit_base +: DIGIT];
      sum_ext    = {1'b0, w1_dig} + {1'b0, w2_dig} + {{DIGIT{1'b0}}, cin_q};
      is_arith   = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_LTU) || (op_q == OP_LT);
      case (op_q)
         OP_AND:        dig_res = w1_dig & w2_dig;
         OP_OR:         dig_res = w1_dig | w2_dig;
         OP_XOR, OP_EQ: dig_res = w1_dig ^ w2_dig;
         default:       dig_res = sum_ext[DIGIT-1:0];
      endcase
      result_nxt = result_q;
      result_nxt[digit_base +: DIGIT] = dig_res;

      last_dig   = (idx_q == LW'(N - 1));
      early_exit = (op_q == OP_ADD) && (idx_q >= len_q) && (sum_ext[DIGIT] == fill_q);
      finish     = last_dig || early_exit;

      w1_sign = result_q[XLEN-1];
      w2_sign = ~w2x_q[XLEN-1];
      case (op_q)
         OP_EQ:   flag_d = eq_acc_q & (dig_res == '0);
         OP_LTU:  flag_d = ~sum_ext[DIGIT];
         OP_LT:   flag_d = (w1_sign != w2_sign) ? w1_sign : ~sum_ext[DIGIT];
         default: flag_d = 1'b0;
      endcase
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_RUN;
         S_RUN: begin
            if (flush)       state_d = S_IDLE;
            else if (finish) state_d = S_DONE;
         end
         S_DONE:  state_d = accept ? S_RUN : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy = (state_q == S_RUN);
      done = (state_q == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
      if (!rst_n) begin
         op_q     <= OP_ADD;
         len_q    <= '0;
         idx_q    <= '0;
         cin_q    <= 1'b0;
         eq_acc_q <= 1'b0;
         fill_q   <= 1'b0;
         w2x_q    <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         flag_q   <= 1'b0;
         zero_q   <= 1'b0;
      end else if (accept) begin
         op_q     <= op_e'(op);
         len_q    <= len_c;
         idx_q    <= '0;
         cin_q    <= op_inv;
         eq_acc_q <= 1'b1;
         fill_q   <= fill;
         w2x_q    <= w2_ext;
         result_q <= word1;
         carry_q  <= 1'b0;
         flag_q   <= 1'b0;
         zero_q   <= 1'b0;
      end else if (state_q == S_RUN && !flush) begin
         result_q <= result_nxt;
         cin_q    <= sum_ext[DIGIT];
         eq_acc_q <= eq_acc_q & (dig_res == '0);
         idx_q    <= idx_q + LW'(1);
         if (finish) begin
            carry_q <= is_arith & sum_ext[DIGIT];
            flag_q  <= flag_d;
            zero_q  <= (result_nxt == '0);
         end
      end
   end

   assign result = result_q;
   assign carry  = carry_q;
   assign flag   = flag_q;
   assign zero   = zero_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq: DIGIT=4 instance for arithmetic, compares and handshake,
// plus a DIGIT=8 instance for the wide-digit carry and early-exit cases.
module tb_serial_alu_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, start8 = 1'b0, flush = 1'b0, w2_signed = 1'b0;
   logic [2:0]  op = 3'b000;
   logic [2:0]  len = 3'd0;
   logic [1:0]  len8 = 2'd0;
   logic [31:0] word1 = '0, word2 = '0;

   logic        busy, done, carry, flag, zero;
   logic [31:0] result;
   logic        busy8, done8, carry8, flag8, zero8;
   logic [31:0] result8;

   int checks = 0;
   int failures = 0;
   int lat, ndone;

   always #5 clk = ~clk;

   serial_alu_seq #(.XLEN(32), .DIGIT(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .op(op), .len(len),
      .w2_signed(w2_signed), .word1(word1), .word2(word2), .busy(busy), .done(done),
      .result(result), .carry(carry), .flag(flag), .zero(zero)
   );

   serial_alu_seq #(.XLEN(32), .DIGIT(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .flush(flush), .op(op), .len(len8),
      .w2_signed(w2_signed), .word1(word1), .word2(word2), .busy(busy8), .done(done8),
      .result(result8), .carry(carry8), .flag(flag8), .zero(zero8)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] o, input logic [2:0] l, input logic s,
                        input logic [31:0] a, input logic [31:0] b);
      op = o; len = l; w2_signed = s; word1 = a; word2 = b;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Counts edges after the accept edge until done; a bound overrun shows up as done=0.
   task automatic wait_done(input string tag, output int n);
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      check({tag, "_done"}, {31'b0, done}, 32'd1);
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_result", result, 32'h0);
      check("rst_flags", {29'b0, carry, flag, zero}, 32'd0);
      rst_n = 1'b1;
      step();

      // ADD with early exit at digit 2
      issue(3'b000, 3'd2, 1'b0, 32'h0000_00FF, 32'h0000_0001);
      check("add_ee_busy", {31'b0, busy}, 32'd1);
      wait_done("add_ee", lat);
      check("add_ee_lat", lat, 32'd3);
      check("add_ee_busy_done", {31'b0, busy}, 32'd0);
      check("add_ee_result", result, 32'h0000_0100);
      check("add_ee_carry", {31'b0, carry}, 32'd0);
      step();
      check("add_ee_pulse", {31'b0, done}, 32'd0);

      // ADD with sign-extended short word2, no early exit
      issue(3'b000, 3'd2, 1'b1, 32'h0000_007B, 32'h0000_0800);
      wait_done("add_sx", lat);
      check("add_sx_lat", lat, 32'd8);
      check("add_sx_result", result, 32'hFFFF_F87B);
      check("add_sx_cz", {30'b0, carry, zero}, 32'd0);
      step();

      // SUB and compares
      issue(3'b001, 3'd7, 1'b0, 32'd5, 32'd7);
      wait_done("sub", lat);
      check("sub_result", result, 32'hFFFF_FFFE);
      check("sub_carry", {31'b0, carry}, 32'd0);
      check("sub_flag", {31'b0, flag}, 32'd0);
      step();
      issue(3'b111, 3'd7, 1'b0, 32'hFFFF_FFFF, 32'd1);
      wait_done("lt", lat);
      check("lt_flag", {31'b0, flag}, 32'd1);
      step();
      issue(3'b110, 3'd7, 1'b0, 32'hFFFF_FFFF, 32'd1);
      wait_done("ltu", lat);
      check("ltu_flag", {31'b0, flag}, 32'd0);
      check("ltu_carry", {31'b0, carry}, 32'd1);
      step();

      // EQ equal and unequal
      issue(3'b101, 3'd7, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      wait_done("eq1", lat);
      check("eq1_lat", lat, 32'd8);
      check("eq1_flag_zero", {30'b0, flag, zero}, 32'd3);
      check("eq1_result", result, 32'h0);
      step();
      issue(3'b101, 3'd7, 1'b0, 32'hDEAD_BEEF, 32'h5EAD_BEEF);
      wait_done("eq0", lat);
      check("eq0_flag_zero", {30'b0, flag, zero}, 32'd0);
      check("eq0_result", result, 32'h8000_0000);
      step();

      // start held through busy, operands changed mid-run: one done, no re-sampling
      op = 3'b000; len = 3'd7; w2_signed = 1'b0; word1 = 32'd1; word2 = 32'd1;
      start = 1'b1;
      step();
      word1 = 32'h0000_FFFF;
      for (int i = 0; i < 6; i++) step();
      start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         if (done === 1'b1) ndone++;
         step();
      end
      check("hold_ndone", ndone, 32'd1);
      check("hold_result", result, 32'd2);

      // Back-to-back: start in the done cycle
      issue(3'b001, 3'd7, 1'b0, 32'd10, 32'd3);
      wait_done("b2b_a", lat);
      check("b2b_a_result", result, 32'd7);
      op = 3'b100; word1 = 32'hF0F0_F0F0; word2 = 32'hFFFF_0000;
      start = 1'b1;
      step();
      start = 1'b0;
      check("b2b_busy_done", {30'b0, busy, done}, 32'd2);
      wait_done("b2b_b", lat);
      check("b2b_b_lat", lat, 32'd8);
      check("b2b_b_result", result, 32'h0F0F_F0F0);
      step();

      // Flush at cycle 3: no done pulse afterwards
      issue(3'b000, 3'd7, 1'b0, 32'h0000_0100, 32'd1);
      for (int i = 0; i < 3; i++) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_busy_done", {30'b0, busy, done}, 32'd0);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         if (done === 1'b1) ndone++;
         step();
      end
      check("flush_ndone", ndone, 32'd0);

      // flush and start together while idle: nothing accepted
      flush = 1'b1; start = 1'b1;
      step();
      flush = 1'b0; start = 1'b0;
      check("flush_start_busy", {31'b0, busy}, 32'd0);

      // Asynchronous reset mid-run, then a fresh accept right after release
      issue(3'b000, 3'd7, 1'b0, 32'h1234_5678, 32'd1);
      step();
      step();
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy_done", {30'b0, busy, done}, 32'd0);
      check("rst_mid_result", result, 32'h0);
      check("rst_mid_flags", {29'b0, carry, flag, zero}, 32'd0);
      #2;
      rst_n = 1'b1;
      issue(3'b000, 3'd7, 1'b0, 32'h1234_5678, 32'd1);
      wait_done("post_rst", lat);
      check("post_rst_lat", lat, 32'd8);
      check("post_rst_result", result, 32'h1234_5679);
      step();

      // DIGIT=8 instance: carry ripples through every digit, no early exit
      op = 3'b000; w2_signed = 1'b0; word1 = 32'hFFFF_FFFF; word2 = 32'd1; len8 = 2'd0;
      start8 = 1'b1;
      step();
      start8 = 1'b0;
      lat = 0;
      while (done8 !== 1'b1 && lat < 40) begin
         step();
         lat++;
      end
      check("d8_full_lat", lat, 32'd4);
      check("d8_full_result", result8, 32'h0);
      check("d8_full_cz", {30'b0, carry8, zero8}, 32'd3);
      step();

      // DIGIT=8 instance: early exit at digit 1
      word1 = 32'h0000_00FF; word2 = 32'd1; len8 = 2'd0;
      start8 = 1'b1;
      step();
      start8 = 1'b0;
      lat = 0;
      while (done8 !== 1'b1 && lat < 40) begin
         step();
         lat++;
      end
      check("d8_ee_lat", lat, 32'd2);
      check("d8_ee_result", result8, 32'h0000_0100);
      check("d8_ee_carry", {31'b0, carry8}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
